pc_fetch_stage: RTL and testbench
=================================

// Module: pc_fetch_stage
// PURPOSE
//  Program counter and instruction-fetch stage of the five-stage pipeline; consumes NextAddress from the J/JR/branch next-address mux.
//  Holds the PC and issues requests to instruction memory over a req/ack handshake of variable latency.
//  Loads the IF/ID pipeline register and honours Stall/Flush from the hazard unit.
//  A redirect that arrives while a fetch is in flight is stored until that fetch completes.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value after reset
//  NOP_INSTR  32'h0000_0000  instruction placed in IF_ID_Instruction when the register is flushed or reset
// PORTS
//  Clk               in   1   single clock; all state updates on the rising edge
//  Rst_n             in   1   synchronous, active-low reset
//  Redirect          in   1   take NextAddress as the next PC (J, JR or taken branch resolved)
//  NextAddress       in   32  redirect target from the next-address mux
//  Stall             in   1   hazard unit: freeze PC advance and IF/ID
//  Flush             in   1   hazard unit: bubble IF/ID on the next edge
//  IMemReq           out  1   fetch request valid
//  IMemAddr          out  32  fetch address; equals PC; stable while IMemReq=1 and no ack
//  IMemAck           in   1   memory returns data this cycle; meaningful only while IMemReq=1
//  IMemRData         in   32  instruction word; valid when IMemAck=1
//  PCPlus4           out  32  PC+4, combinational, mod 2^32
//  IF_ID_PC          out  32  PC of the instruction in IF/ID
//  IF_ID_PCPlus4     out  32  that PC + 4 (feeds the branch adder)
//  IF_ID_Instruction out  32  fetched instruction
//  IF_ID_Valid       out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (Rst_n=0 at an edge):
//   - PC=RESET_PC, state=REQ, IMemReq=0 while Rst_n=0.
//   - IF_ID_*: Valid=0, Instruction=NOP_INSTR, PC=0, PCPlus4=0.
//   - Pending=0, skid buffer cleared.
//   - Reset mid-transaction abandons the outstanding request; memory must tolerate this.
//  FSM states: REQ, HOLD, DISCARD.
//  REQ (IMemReq=1, IMemAddr=PC):
//   - ack & !Stall & !Redirect: IF/ID <= {PC, PC+4, IMemRData, Valid=1}; PC <= PC+4; stay in REQ.
//     Throughput is 1 instr/cycle with zero-wait memory.
//   - ack & Stall & !Redirect: capture {PC, IMemRData} in the skid buffer; PC <= PC+4; go to HOLD.
//   - ack & Redirect: drop the data; PC <= {NextAddress[31:2], 2'b00}; stay in REQ.
//   - !ack & Redirect: Pending=1, PendTgt <= aligned NextAddress; go to DISCARD.
//     PC and IMemAddr stay unchanged (handshake rule: address is held until ack).
//   - !ack & !Redirect: hold.
//  HOLD (IMemReq=0):
//   - !Stall: IF/ID <= skid buffer with Valid=1; go to REQ.
//   - Redirect in HOLD: drop the buffer; PC <= aligned NextAddress; go to REQ.
//  DISCARD (IMemReq=1, old address held):
//   - ack: drop the data; PC <= PendTgt; Pending=0; go to REQ.
//   - Another Redirect before ack overwrites PendTgt; the last one wins.
//  Priorities and boundaries:
//   - Redirect updates the PC regardless of Stall.
//   - Stall holds IF/ID unless Flush=1.
//   - Flush forces IF_ID_Valid=0 and IF_ID_Instruction=NOP_INSTR and overrides any IF/ID load in that cycle.
//   - Flush and Redirect are independent inputs; control asserts both on a taken jump.
//   - NextAddress[1:0] are ignored (forced to 00).
//   - PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
// STRUCTURE
//  - Shared package pipe_pkg: fetch_state_t enum {REQ, HOLD, DISCARD}, RESET_PC default, NOP_INSTR, INSTR_W=32.
//  - Sub-module if_id_reg: the IF/ID register, with load, flush and reset priority (reset > flush > stall-hold > load).
//  - This module holds the PC, the FSM, the skid buffer and the pending-redirect register.
// TESTING
//  1. Reset, then memory acks every cycle -> IMemAddr goes 0,4,8,C on consecutive cycles.
//     IF_ID_PC lags IMemAddr by 1 cycle; IF_ID_Valid=1 from the 2nd cycle after reset release.
//  2. Ack with Stall=1 at PC=0x10, Stall low 3 cycles later.
//     -> IMemReq=0 for those 3 cycles, IF/ID frozen; then IF_ID_PC=0x10 with the captured word; next fetch at 0x14.
//  3. Redirect (NextAddress=0x400) at PC=0x20 with 2-cycle memory latency.
//     -> IMemAddr held at 0x20 until ack; the 0x20 data never reaches IF/ID; next IMemAddr=0x400.
//  4. Flush and an ack in the same cycle -> IF_ID_Valid=0 and Instruction=NOP_INSTR; PC still advances.
//  5. Redirect with NextAddress=0x103 -> PC=0x100.
//     Start at PC=0xFFFF_FFFC -> next PC=0x0000_0000.
//  6. Rst_n low while in DISCARD -> PC=RESET_PC, Pending=0, Valid=0.
//     The first fetch after release is at RESET_PC.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants.
// Used by the fetch stage and its IF/ID register.
package pipe_pkg;

  localparam int          INSTR_W       = 32;
  localparam logic [31:0] PKG_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PKG_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]        pc;
    logic [31:0]        pc4;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } if_id_t;

  function automatic logic [31:0] align4(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Priority: reset > flush > stall-hold > load.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = pipe_pkg::PKG_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_stall,
  input  pipe_pkg::if_id_t i_d,
  output pipe_pkg::if_id_t o_q
);
  import pipe_pkg::*;

  if_id_t r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q.pc    <= '0;
      r_q.pc4   <= '0;
      r_q.instr <= NOP_INSTR;
      r_q.valid <= 1'b0;
    end else if (i_flush) begin
      r_q.valid <= 1'b0;
      r_q.instr <= NOP_INSTR;
    end else if (!i_stall) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// PC register, fetch handshake FSM, skid buffer
// and pending-redirect tracking for the IF stage.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC  = pipe_pkg::PKG_RESET_PC,
  parameter logic [31:0] NOP_INSTR = pipe_pkg::PKG_NOP_INSTR
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Redirect,
  input  logic [31:0] NextAddress,
  input  logic        Stall,
  input  logic        Flush,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRData,
  output logic [31:0] PCPlus4,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PCPlus4,
  output logic [31:0] IF_ID_Instruction,
  output logic        IF_ID_Valid
);
  import pipe_pkg::*;

  fetch_state_t r_state, w_state_n;
  logic [31:0]  r_pc, w_pc_n;
  logic         r_pending, w_pending_n;
  logic [31:0]  r_pend_tgt, w_pend_tgt_n;
  logic [31:0]  r_skid_pc, r_skid_instr;
  logic         w_skid_cap;
  logic [31:0]  w_pc4, w_tgt;
  if_id_t       w_d, w_q;

  assign w_pc4    = r_pc + 32'd4;
  assign w_tgt    = align4(NextAddress);
  assign PCPlus4  = w_pc4;
  assign IMemAddr = r_pc;
  assign IMemReq  = Rst_n && (r_state != HOLD);

  always_comb begin
    w_state_n    = r_state;
    w_pc_n       = r_pc;
    w_pending_n  = r_pending;
    w_pend_tgt_n = r_pend_tgt;
    w_skid_cap   = 1'b0;
    w_d.pc       = r_pc;
    w_d.pc4      = w_pc4;
    w_d.instr    = NOP_INSTR;
    w_d.valid    = 1'b0;
    unique case (r_state)
      REQ: begin
        if (IMemAck && Redirect) begin
          w_pc_n = w_tgt;
        end else if (IMemAck && Stall) begin
          w_skid_cap = 1'b1;
          w_pc_n     = w_pc4;
          w_state_n  = HOLD;
        end else if (IMemAck) begin
          w_d.instr = IMemRData;
          w_d.valid = 1'b1;
          w_pc_n    = w_pc4;
        end else if (Redirect) begin
          w_pending_n  = 1'b1;
          w_pend_tgt_n = w_tgt;
          w_state_n    = DISCARD;
        end
      end
      HOLD: begin
        if (Redirect) begin
          w_pc_n    = w_tgt;
          w_state_n = REQ;
        end else if (!Stall) begin
          w_d.pc    = r_skid_pc;
          w_d.pc4   = r_skid_pc + 32'd4;
          w_d.instr = r_skid_instr;
          w_d.valid = 1'b1;
          w_state_n = REQ;
        end
      end
      DISCARD: begin
        // A redirect landing with the ack is the newest target.
        if (IMemAck) begin
          w_pc_n      = Redirect ? w_tgt : r_pend_tgt;
          w_pending_n = 1'b0;
          w_state_n   = REQ;
        end else if (Redirect) begin
          w_pend_tgt_n = w_tgt;
        end
      end
      default: w_state_n = REQ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state      <= REQ;
      r_pc         <= RESET_PC;
      r_pending    <= 1'b0;
      r_pend_tgt   <= '0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_pending  <= w_pending_n;
      r_pend_tgt <= w_pend_tgt_n;
      if (w_skid_cap) begin
        r_skid_pc    <= r_pc;
        r_skid_instr <= IMemRData;
      end
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .i_flush (Flush),
    .i_stall (Stall),
    .i_d     (w_d),
    .o_q     (w_q)
  );

  assign IF_ID_PC          = w_q.pc;
  assign IF_ID_PCPlus4     = w_q.pc4;
  assign IF_ID_Instruction = w_q.instr;
  assign IF_ID_Valid       = w_q.valid;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed scenarios
// plus random traffic against a behavioural model.
module tb_pc_fetch_stage;

  localparam logic [31:0] RST = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Rst_n, Redirect, Stall, Flush, IMemAck;
  logic [31:0] NextAddress, IMemRData;
  logic        IMemReq, IF_ID_Valid;
  logic [31:0] IMemAddr, PCPlus4, IF_ID_PC, IF_ID_PCPlus4, IF_ID_Instruction;

  int checks = 0;
  int failures = 0;

  // model state
  logic [31:0] m_pc, m_tgt, m_spc, m_sins;
  logic [31:0] m_ipc, m_ipc4, m_ins;
  bit          m_hold, m_disc, m_v;

  always #5 Clk = ~Clk;

  pc_fetch_stage dut (
    .Clk               (Clk),
    .Rst_n             (Rst_n),
    .Redirect          (Redirect),
    .NextAddress       (NextAddress),
    .Stall             (Stall),
    .Flush             (Flush),
    .IMemReq           (IMemReq),
    .IMemAddr          (IMemAddr),
    .IMemAck           (IMemAck),
    .IMemRData         (IMemRData),
    .PCPlus4           (PCPlus4),
    .IF_ID_PC          (IF_ID_PC),
    .IF_ID_PCPlus4     (IF_ID_PCPlus4),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_Valid       (IF_ID_Valid)
  );

  task automatic m_step();
    logic [31:0] t, dpc, dins;
    bit dlv;
    t = NextAddress & 32'hFFFF_FFFC;
    dlv = 0;
    dpc = 0;
    dins = 0;
    if (!Rst_n) begin
      m_pc = RST; m_hold = 0; m_disc = 0; m_tgt = 0;
      m_v = 0; m_ins = NOP; m_ipc = 0; m_ipc4 = 0;
      return;
    end
    if (m_hold) begin
      if (Redirect) begin m_pc = t; m_hold = 0; end
      else if (!Stall) begin
        dlv = 1; dpc = m_spc; dins = m_sins; m_hold = 0;
      end
    end else if (m_disc) begin
      if (IMemAck) begin m_pc = Redirect ? t : m_tgt; m_disc = 0; end
      else if (Redirect) m_tgt = t;
    end else if (IMemAck) begin
      if (Redirect) m_pc = t;
      else if (Stall) begin
        m_spc = m_pc; m_sins = IMemRData; m_pc = m_pc + 4; m_hold = 1;
      end else begin
        dlv = 1; dpc = m_pc; dins = IMemRData; m_pc = m_pc + 4;
      end
    end else if (Redirect) begin
      m_disc = 1; m_tgt = t;
    end
    if (Flush) begin
      m_v = 0; m_ins = NOP;
    end else if (!Stall) begin
      m_v = dlv;
      m_ins = dlv ? dins : NOP;
      if (dlv) begin m_ipc = dpc; m_ipc4 = dpc + 4; end
    end
  endtask

  task automatic apply(input bit rn, input bit rd, input logic [31:0] na,
                       input bit st, input bit fl, input bit ak,
                       input logic [31:0] rdat);
    Rst_n = rn; Redirect = rd; NextAddress = na;
    Stall = st; Flush = fl; IMemAck = ak; IMemRData = rdat;
    #1;
  endtask

  task automatic step();
    m_step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    apply(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
  endtask

  task automatic test_reset();
    apply(0, 0, 0, 0, 0, 0, 0);
    step();
    checks++;
    if (IMemReq !== 1'b0) begin
      failures++; $display("FAIL reset_req got=%b exp=0", IMemReq);
    end
    checks++;
    if (IMemAddr !== RST) begin
      failures++; $display("FAIL reset_pc got=%h exp=%h", IMemAddr, RST);
    end
    checks++;
    if ({IF_ID_Valid, IF_ID_Instruction, IF_ID_PC, IF_ID_PCPlus4}
        !== {1'b0, NOP, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_ifid got=%b/%h/%h/%h exp=0/%h/0/0",
               IF_ID_Valid, IF_ID_Instruction, IF_ID_PC, IF_ID_PCPlus4, NOP);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] w;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      w = $urandom;
      apply(1, 0, 0, 0, 0, 1, w);
      checks++;
      if (IMemReq !== 1'b1 || IMemAddr !== 32'(4 * k)) begin
        failures++;
        $display("FAIL seq_addr k=%0d got=%b/%h exp=1/%h", k, IMemReq, IMemAddr, 4 * k);
      end
      checks++;
      if (IF_ID_Valid !== (k >= 1) ||
          (k >= 1 && (IF_ID_PC !== 32'(4 * (k - 1)) || IF_ID_Instruction !== m_ins))) begin
        failures++;
        $display("FAIL seq_ifid k=%0d got=%b/%h/%h exp=%b/%h/%h", k, IF_ID_Valid,
                 IF_ID_PC, IF_ID_Instruction, k >= 1, 4 * (k - 1), m_ins);
      end
      step();
    end
  endtask

  task automatic test_stall_skid();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply(1, 0, 0, 0, 0, 1, 32'h1000 + k);
      step();
    end
    apply(1, 0, 0, 1, 0, 1, 32'hCAFE_0010);
    step();
    for (int k = 0; k < 3; k++) begin
      apply(1, 0, 0, 1, 0, 1, 32'hBAD0_0000);
      checks++;
      if (IMemReq !== 1'b0 || IF_ID_PC !== 32'hC || IF_ID_Instruction !== 32'h1003) begin
        failures++;
        $display("FAIL stall_hold k=%0d got=%b/%h/%h exp=0/c/1003", k,
                 IMemReq, IF_ID_PC, IF_ID_Instruction);
      end
      step();
    end
    apply(1, 0, 0, 0, 0, 0, 0);
    step();
    apply(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (IF_ID_Valid !== 1'b1 || IF_ID_PC !== 32'h10 ||
        IF_ID_Instruction !== 32'hCAFE_0010 || IF_ID_PCPlus4 !== 32'h14) begin
      failures++;
      $display("FAIL stall_release got=%b/%h/%h exp=1/10/cafe0010",
               IF_ID_Valid, IF_ID_PC, IF_ID_Instruction);
    end
    checks++;
    if (IMemReq !== 1'b1 || IMemAddr !== 32'h14) begin
      failures++; $display("FAIL stall_next got=%b/%h exp=1/14", IMemReq, IMemAddr);
    end
  endtask

  task automatic test_redirect_latency();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      apply(1, 0, 0, 0, 0, 1, $urandom);
      step();
    end
    apply(1, 1, 32'h400, 0, 0, 0, 0);
    step();
    apply(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (IMemReq !== 1'b1 || IMemAddr !== 32'h20) begin
      failures++; $display("FAIL redir_held got=%b/%h exp=1/20", IMemReq, IMemAddr);
    end
    step();
    apply(1, 0, 0, 0, 0, 1, 32'hDEAD_0020);
    checks++;
    if (IMemAddr !== 32'h20) begin
      failures++; $display("FAIL redir_held2 got=%h exp=20", IMemAddr);
    end
    step();
    apply(1, 0, 0, 0, 0, 1, 32'h0400_0001);
    checks++;
    if (IMemAddr !== 32'h400 || IF_ID_Valid !== 1'b0) begin
      failures++;
      $display("FAIL redir_target got=%h/%b exp=400/0", IMemAddr, IF_ID_Valid);
    end
    step();
    apply(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (IF_ID_Valid !== 1'b1 || IF_ID_PC !== 32'h400 || IF_ID_Instruction !== 32'h0400_0001) begin
      failures++;
      $display("FAIL redir_first got=%b/%h/%h exp=1/400/04000001",
               IF_ID_Valid, IF_ID_PC, IF_ID_Instruction);
    end
  endtask

  task automatic test_flush();
    do_reset();
    apply(1, 0, 0, 0, 0, 1, 32'h1111_1111);
    step();
    apply(1, 0, 0, 0, 1, 1, 32'h2222_2222);
    step();
    apply(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (IF_ID_Valid !== 1'b0 || IF_ID_Instruction !== NOP || IMemAddr !== 32'h8) begin
      failures++;
      $display("FAIL flush got=%b/%h/%h exp=0/%h/8", IF_ID_Valid,
               IF_ID_Instruction, IMemAddr, NOP);
    end
  endtask

  task automatic test_align_wrap();
    do_reset();
    apply(1, 1, 32'h103, 0, 0, 1, 0);
    step();
    apply(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (IMemAddr !== 32'h100) begin
      failures++; $display("FAIL align got=%h exp=100", IMemAddr);
    end
    apply(1, 1, 32'hFFFF_FFFF, 0, 0, 1, 0);
    step();
    apply(1, 0, 0, 0, 0, 1, 32'h7777_0000);
    checks++;
    if (IMemAddr !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin
      failures++; $display("FAIL wrap_pc got=%h/%h exp=fffffffc/0", IMemAddr, PCPlus4);
    end
    step();
    apply(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (IMemAddr !== 32'h0 || IF_ID_PC !== 32'hFFFF_FFFC || IF_ID_PCPlus4 !== 32'h0) begin
      failures++;
      $display("FAIL wrap_next got=%h/%h/%h exp=0/fffffffc/0",
               IMemAddr, IF_ID_PC, IF_ID_PCPlus4);
    end
  endtask

  task automatic test_reset_discard();
    do_reset();
    apply(1, 0, 0, 0, 0, 1, 32'h5);
    step();
    apply(1, 1, 32'h800, 0, 0, 0, 0);
    step();
    apply(0, 0, 0, 0, 0, 0, 0);
    step();
    apply(1, 0, 0, 0, 0, 1, 32'h9999_0000);
    checks++;
    if (IMemAddr !== RST || IF_ID_Valid !== 1'b0 || IMemReq !== 1'b1) begin
      failures++;
      $display("FAIL rst_discard got=%h/%b/%b exp=%h/0/1", IMemAddr, IF_ID_Valid, IMemReq, RST);
    end
    step();
    apply(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (IMemAddr !== 32'h4 || IF_ID_PC !== RST || IF_ID_Valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_discard_fetch got=%h/%h/%b exp=4/%h/1", IMemAddr, IF_ID_PC, IF_ID_Valid, RST);
    end
  endtask

  task automatic test_random();
    bit rn;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rn = ($urandom_range(63) != 0);
      apply(rn, $urandom_range(7) == 0, $urandom, $urandom_range(3) == 0,
            $urandom_range(9) == 0, $urandom_range(2) != 0, $urandom);
      checks++;
      if (IMemReq !== (rn && !m_hold) || IMemAddr !== m_pc || PCPlus4 !== m_pc + 32'd4) begin
        failures++;
        $display("FAIL rnd_fetch n=%0d got=%b/%h/%h exp=%b/%h/%h", n, IMemReq,
                 IMemAddr, PCPlus4, rn && !m_hold, m_pc, m_pc + 32'd4);
      end
      checks++;
      if (IF_ID_Valid !== m_v || IF_ID_Instruction !== m_ins ||
          (m_v && (IF_ID_PC !== m_ipc || IF_ID_PCPlus4 !== m_ipc4))) begin
        failures++;
        $display("FAIL rnd_ifid n=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h", n,
                 IF_ID_Valid, IF_ID_Instruction, IF_ID_PC, IF_ID_PCPlus4,
                 m_v, m_ins, m_ipc, m_ipc4);
      end
      step();
    end
  endtask

  initial begin
    m_pc = RST; m_tgt = 0; m_spc = 0; m_sins = 0;
    m_ipc = 0; m_ipc4 = 0; m_ins = NOP;
    m_hold = 0; m_disc = 0; m_v = 0;
    @(negedge Clk);
    test_reset();
    test_sequential();
    test_stall_skid();
    test_redirect_latency();
    test_flush();
    test_align_wrap();
    test_reset_discard();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
